// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake bundle for uart_tx_cfg: producer pushes words, UART grants.
interface uart_tx_cfg_if #(
  parameter int BYTE_WIDTH = 1
);
  logic                    wreq;
  logic                    wgnt;
  logic [BYTE_WIDTH*8-1:0] wdata;

  modport master (output wreq, output wdata, input wgnt);
  modport slave  (input wreq, input wdata, output wgnt);
endinterface

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter: multi-byte words serialised with a per-word
// latched frame format (5-8 data bits, none/odd/even parity, 1 or 2 stops).
module uart_tx_cfg #(
  parameter int DIV_W      = 16,
  parameter int FIFO_ASIZE = 9,
  parameter int BYTE_WIDTH = 1,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                clk,
  input  logic                rstn,
  uart_tx_cfg_if.slave        wbus,
  input  logic                flush,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [1:0]          data_bits,
  input  logic [1:0]          parity,
  input  logic                stop2,
  output logic [FIFO_ASIZE:0] level,
  output logic                busy,
  output logic                tx_done,
  output logic                o_uart_tx
);
  localparam int WW    = BYTE_WIDTH * 8;
  localparam int DEPTH = 1 << FIFO_ASIZE;
  localparam int BIW   = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam bit BE    = (BIG_ENDIAN != 0);
  localparam logic [FIFO_ASIZE:0] FULL_LVL = {1'b1, {FIFO_ASIZE{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_e;

  // FIFO
  logic [WW-1:0]         mem [DEPTH];
  logic [WW-1:0]         rd_q;
  logic [FIFO_ASIZE-1:0] wptr_q, rptr_q;
  logic [FIFO_ASIZE:0]   cnt_q;
  logic                  full, push, pop;

  // serialiser
  state_e           state_q;
  logic [WW-1:0]    word_q;
  logic [BIW-1:0]   byte_q;
  logic [7:0]       sh_q;
  logic [2:0]       bit_q;
  logic [DIV_W-1:0] tmr_q, div_q;
  logic [1:0]       dbits_q, par_q;
  logic             stop2_q, stopn_q;
  logic             tx_q, busy_q, done_q;

  logic [BIW-1:0] bsel;
  logic [7:0]     cur_byte, mask;
  logic           bit_end, par_en, par_bit;

  assign full      = (cnt_q == FULL_LVL);
  assign wbus.wgnt = wbus.wreq & ~full;
  assign push      = wbus.wgnt & ~flush;
  assign pop       = (state_q == IDLE) && (cnt_q != '0) && !flush;

  assign level     = cnt_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;
  assign o_uart_tx = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_ASIZE'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_ASIZE'(1);
      if (push && !pop)      cnt_q <= cnt_q + (FIFO_ASIZE+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (FIFO_ASIZE+1)'(1);
    end
  end

  // rd_q holds the popped word through FETCH and LOAD
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wbus.wdata;
    if (pop)  rd_q <= mem[rptr_q];
  end

  always_comb begin
    bsel     = BE ? (BIW'(BYTE_WIDTH - 1) - byte_q) : byte_q;
    cur_byte = word_q[bsel*8 +: 8];
    mask     = 8'hFF >> (2'd3 - dbits_q);
    par_en   = (par_q == 2'd1) || (par_q == 2'd2);
    par_bit  = (par_q == 2'd1) ? ~^(cur_byte & mask) : ^(cur_byte & mask);
    bit_end  = (tmr_q == div_q - DIV_W'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      div_q   <= DIV_W'(2);
      dbits_q <= '0;
      par_q   <= '0;
      stop2_q <= 1'b0;
      stopn_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q inside {START, DATA, PARITY, STOP})
        tmr_q <= bit_end ? '0 : tmr_q + DIV_W'(1);
      case (state_q)
        IDLE: if (pop) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          word_q  <= rd_q;
          byte_q  <= '0;
          div_q   <= (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
          dbits_q <= data_bits;
          par_q   <= parity;
          stop2_q <= stop2;
          tmr_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (bit_end) begin
          tx_q    <= cur_byte[0];
          sh_q    <= {1'b0, cur_byte[7:1]};
          bit_q   <= '0;
          state_q <= DATA;
        end
        // last data bit index is data_bits+4
        DATA: if (bit_end) begin
          if (bit_q == {1'b1, dbits_q}) begin
            if (par_en) begin
              tx_q    <= par_bit;
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              stopn_q <= 1'b0;
              state_q <= STOP;
            end
          end else begin
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
            bit_q <= bit_q + 3'd1;
          end
        end
        PARITY: if (bit_end) begin
          tx_q    <= 1'b1;
          stopn_q <= 1'b0;
          state_q <= STOP;
        end
        STOP: if (bit_end) begin
          if (stop2_q && !stopn_q) begin
            stopn_q <= 1'b1;
          end else if (byte_q == BIW'(BYTE_WIDTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            byte_q  <= byte_q + BIW'(1);
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
